// File: rtl/key_pio_pkg.sv
// Register map shared by the key PIO top, its bus interface and the testbench.
package key_pio_pkg;

    localparam int ADDR_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_DATA     = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_RAW      = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_RISE_EN  = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_FALL_EN  = 3'd5;

endpackage

// File: rtl/debounced_key_pio_if.sv
// Avalon-MM slave bus of the key PIO (word addressed, no wait states, read latency 1).
interface debounced_key_pio_if;
    import key_pio_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/key_debounce_cell.sv
// One input channel: polarity fix, 2-flop synchroniser, counter debounce, edge detect.
// The synchroniser holds the logical level, so its reset value 0 equals the idle pin
// level and no edge is reported when reset is released.
module key_debounce_cell #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    input  logic invert,
    output logic sync_level,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]   CNT_MAX  = '1;

    logic          s1;
    logic          s2;
    logic          stable_d;
    logic [CW-1:0] count;

    // Bring the asynchronous pin into the clk domain as a logical level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw ^ invert;
            s2 <= s1;
        end
    end

    // Accept a new level only after it has differed from stable for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable <= 1'b0;
            count  <= '0;
        end else if (s2 != stable) begin
            if (count == CNT_LAST) begin
                stable <= s2;
                count  <= '0;
            end else if (count != CNT_MAX) begin
                count <= count + 1'b1;
            end
        end else begin
            count <= '0;
        end
    end

    // Delayed copy of the debounced level for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) stable_d <= 1'b0;
        else          stable_d <= stable;
    end

    assign sync_level = s2;
    assign rise       = stable & ~stable_d;
    assign fall       = ~stable & stable_d;

endmodule

// File: rtl/debounced_key_pio.sv
// Debounced push-button/switch input PIO with edge capture and level IRQ on Avalon-MM.
module debounced_key_pio
    import key_pio_pkg::*;
#(
    parameter int               WIDTH           = 4,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter logic [WIDTH-1:0] INPUT_INVERT    = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] RISE_EN_RESET   = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] FALL_EN_RESET   = {WIDTH{1'b0}}
) (
    input  logic                 clk,
    input  logic                 reset_n,
    debounced_key_pio_if.slave   bus,
    input  logic [WIDTH-1:0]     in_port,
    output logic                 irq
);

    logic [WIDTH-1:0] sync_lvl;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] cap_set;
    logic [WIDTH-1:0] cap_clr;
    logic [31:0]      rd_mux;
    logic [31:0]      readdata_q;
    logic             wr_en;
    logic             unused_wdata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        key_debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cell (
            .clk        (clk),
            .reset_n    (reset_n),
            .raw        (in_port[i]),
            .invert     (INPUT_INVERT[i]),
            .sync_level (sync_lvl[i]),
            .stable     (stable[i]),
            .rise       (rise[i]),
            .fall       (fall[i])
        );
    end

    assign wr_en        = bus.chipselect & ~bus.write_n;
    assign wdata        = bus.writedata[WIDTH-1:0];
    assign unused_wdata = ^bus.writedata;

    // Writable mode and mask registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask <= '0;
            rise_en  <= RISE_EN_RESET;
            fall_en  <= FALL_EN_RESET;
        end else if (wr_en) begin
            case (bus.address)
                ADDR_IRQ_MASK: irq_mask <= wdata;
                ADDR_RISE_EN:  rise_en  <= wdata;
                ADDR_FALL_EN:  fall_en  <= wdata;
                default: ;
            endcase
        end
    end

    assign cap_set = (rise & rise_en) | (fall & fall_en);
    assign cap_clr = (wr_en && (bus.address == ADDR_EDGE_CAP)) ? wdata : '0;

    // Edge capture: a new edge wins over a same-cycle write-1-to-clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) edge_cap <= '0;
        else          edge_cap <= cap_set | (edge_cap & ~cap_clr);
    end

    // Read mux; unused upper bits and reserved addresses return 0.
    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_DATA:     rd_mux[WIDTH-1:0] = stable;
            ADDR_RAW:      rd_mux[WIDTH-1:0] = sync_lvl;
            ADDR_IRQ_MASK: rd_mux[WIDTH-1:0] = irq_mask;
            ADDR_EDGE_CAP: rd_mux[WIDTH-1:0] = edge_cap;
            ADDR_RISE_EN:  rd_mux[WIDTH-1:0] = rise_en;
            ADDR_FALL_EN:  rd_mux[WIDTH-1:0] = fall_en;
            default:       rd_mux = '0;
        endcase
    end

    // Registered read data, updated every cycle regardless of chipselect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata_q <= '0;
        else          readdata_q <= rd_mux;
    end

    assign bus.readdata = readdata_q;
    assign irq          = |(edge_cap & irq_mask);

endmodule
